eightbit_mem: RTL and testbench
===============================

// Module: eightbit_mem
// PURPOSE
//  Synthesizable 256x8 memory responder for the eightbit CPU bus (addr/data/we).
//  Serves CPU reads and writes with one-cycle registered read data.
//  Includes a byte-stream program loader that fills memory and holds the CPU
//  off the bus while a load is in progress. Replaces bench-modelled memory in
//  system builds.
// PARAMETERS
//  AW        8     address width; depth = 2**AW
//  DW        8     data width
//  IO_ADDR   8'hFF address of the memory-mapped I/O register (MEM_IO_PORT_EN only)
// PORTS
//  clk       in   1   system clock; all state updates on posedge
//  rst_n     in   1   synchronous active-low reset
//  addr      in   AW  CPU address
//  data_in   in   DW  CPU write data (the CPU's data_out)
//  data_out  out  DW  registered read data to the CPU (the CPU's data_in)
//  we        in   1   CPU write enable
//  ld_start  in   1   pulse: begin a load at ld_base for ld_len bytes
//  ld_base   in   AW  load start address, sampled with ld_start
//  ld_len    in   AW  byte count, sampled with ld_start; 0 means 256
//  ld_valid  in   1   loader byte valid
//  ld_data   in   DW  loader byte
//  ld_ready  out  1   loader accepts a byte this cycle
//  cpu_hold  out  1   high while loading; the CPU must stall or stay in reset
//  io_out    out  DW  I/O output register (MEM_IO_PORT_EN only)
//  io_in     in   DW  I/O input value (MEM_IO_PORT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): data_out=0, ld_ready=0, cpu_hold=0,
//    FSM=IDLE, io_out=0. Array contents are not cleared.
//  - CPU access, state IDLE: at posedge, if we=1 then mem[addr]<=data_in.
//    data_out<=mem[addr] in the same edge, write-first: when we=1,
//    data_out<=data_in. Read latency is 1 cycle.
//  - FSM states:
//    - IDLE: ld_start=1 captures ptr<=ld_base and cnt<=ld_len (0 loads as
//      256), then goes to LOAD.
//    - LOAD: ld_ready=1 and cpu_hold=1, both asserted combinationally from
//      the state. Each ld_valid&ld_ready writes mem[ptr]<=ld_data, increments
//      ptr modulo 256 (0xFF wraps to 0x00) and decrements cnt. Accepting the
//      final byte (cnt==1) returns the FSM to IDLE on that edge.
//  - During LOAD, CPU writes are ignored, data_out holds its last value, and
//    ld_start is ignored.
//  - ld_start together with a CPU write in IDLE: the CPU write completes; the
//    load begins next cycle.
//  - ld_valid while the FSM is not in LOAD: the byte is dropped.
//  - Reset during LOAD: abort to IDLE. Bytes already written remain in memory.
// CONFIGURATION
//  MEM_IO_PORT_EN defined:
//    - CPU write to IO_ADDR updates io_out and does not write the array.
//    - CPU read of IO_ADDR returns io_in, registered like normal reads.
//    - Loader writes to IO_ADDR still go to the array.
//  MEM_IO_PORT_EN undefined:
//    - IO_ADDR is an ordinary array location.
//    - io_out and io_in are not present.
// TESTING
//  1. Reset, then CPU writes 0x0F to 0xE1, then reads 0xE1 -> data_out=0x0F
//     one cycle after addr is presented.
//  2. we=1, addr=0x10, data_in=0xA5 in one cycle -> data_out=0xA5 after that
//     same edge (write-first).
//  3. ld_start with base=0x00, len=4, bytes 05,00,00,00 streamed with gaps in
//     ld_valid -> cpu_hold high for exactly the load duration; mem[0..3] equal
//     the bytes; FSM back in IDLE after the 4th byte.
//  4. ld_start with base=0xFE, len=3, bytes 11,22,33 -> mem[FE]=11,
//     mem[FF]=22, mem[00]=33 (address wrap).
//  5. ld_len=0 -> exactly 256 bytes accepted. ld_start pulsed mid-load is
//     ignored. A CPU write 0x77 during the load is not stored.
//  6. Reset asserted after 2 of 5 load bytes -> ld_ready=0, cpu_hold=0 next
//     cycle; the first 2 bytes remain in memory. With MEM_IO_PORT_EN:
//     write 0x3C to 0xFF -> io_out=0x3C; io_in=0x5A, read 0xFF -> data_out=0x5A.

Source files
------------

// File: rtl/eightbit_mem.sv
// 256x8 memory responder for the eightbit CPU bus with a byte-stream program loader.
// Define MEM_IO_PORT_EN to map an I/O register (io_out/io_in) at IO_ADDR.
module eightbit_mem #(
    parameter int AW = 8,
    parameter int DW = 8
`ifdef MEM_IO_PORT_EN
    ,
    parameter logic [AW-1:0] IO_ADDR = 8'hFF
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    input  logic          we,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW-1:0] ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          cpu_hold
`ifdef MEM_IO_PORT_EN
    ,
    output logic [DW-1:0] io_out,
    input  logic [DW-1:0] io_in
`endif
);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   ptr;
    logic [AW:0]     cnt;          // one extra bit so a length of 0 can count 2**AW bytes
    logic [DW-1:0]   mem [0:(2**AW)-1];

    logic            idle;
    logic            load_wr;
    logic            cpu_wr;
    logic            io_hit;
    logic [DW-1:0]   rd_val;

    assign idle    = (state == IDLE);
    assign load_wr = rst_n && (state == LOAD) && ld_valid;

`ifdef MEM_IO_PORT_EN
    assign io_hit  = (addr == IO_ADDR);
    assign rd_val  = io_hit ? io_in : mem[addr];
`else
    assign io_hit  = 1'b0;
    assign rd_val  = mem[addr];
`endif

    assign cpu_wr  = rst_n && idle && we && !io_hit;

    // State register together with the loader pointer and remaining-byte count.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (idle && ld_start) begin
                ptr <= ld_base;
                cnt <= (ld_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, ld_len};
            end else if (load_wr) begin
                ptr <= ptr + 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (ld_start) state_d = LOAD;
            LOAD:    if (ld_valid && cnt == (AW+1)'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        cpu_hold = 1'b0;
        if (state == LOAD) begin
            ld_ready = 1'b1;
            cpu_hold = 1'b1;
        end
    end

    // NOTE: the array has no reset; clearing it would force flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (load_wr)
            mem[ptr] <= ld_data;
        else if (cpu_wr)
            mem[addr] <= data_in;
    end

    // Write-first read port; frozen while the loader owns the bus.
    always_ff @(posedge clk) begin
        if (!rst_n)
            data_out <= '0;
        else if (idle)
            data_out <= we ? data_in : rd_val;
    end

`ifdef MEM_IO_PORT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            io_out <= '0;
        else if (idle && we && io_hit)
            io_out <= data_in;
    end
`endif

endmodule

// File: tb/tb_eightbit_mem.sv
// Scoreboard bench for eightbit_mem: stimulus pushes expected read data, a monitor pops and compares.
// Covers CPU read/write, write-first, loads with gaps/wrap/256 bytes, reset abort, optional I/O port.
module tb_eightbit_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr, data_in, data_out;
    logic       we;
    logic       ld_start;
    logic [7:0] ld_base, ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready, cpu_hold;
`ifdef MEM_IO_PORT_EN
    logic [7:0] io_out;
    logic [7:0] io_in;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    bit         rd_issue   = 1'b0;
    bit         rd_valid_q = 1'b0;
    logic [7:0] ld_bytes [0:255];
    logic [7:0] held;

    always #5 clk = ~clk;

    eightbit_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .we       (we),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold)
`ifdef MEM_IO_PORT_EN
        ,
        .io_out   (io_out),
        .io_in    (io_in)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Read data is valid one edge after a CPU cycle was presented.
    always @(posedge clk) rd_valid_q <= rd_issue;

    always @(negedge clk) begin
        if (rd_valid_q) begin
            if (exp_q.size() == 0)
                check("scoreboard_underflow", 1, 0);
            else
                check("read_data", data_out, exp_q.pop_front());
        end
    end

    task automatic cpu_cycle(input logic [7:0] a, input bit w, input logic [7:0] d,
                             input logic [7:0] exp);
        @(negedge clk);
        addr = a; we = w; data_in = d; ld_valid = 1'b0; ld_start = 1'b0;
        rd_issue = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        we = 1'b0; ld_valid = 1'b0; ld_start = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] base, input int len, input bit gaps, input bit disturb);
        @(negedge clk);
        rd_issue = 1'b0; we = 1'b0; ld_valid = 1'b0;
        ld_start = 1'b1; ld_base = base; ld_len = 8'(len);
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 2 == 1)) begin
                @(negedge clk);
                ld_start = 1'b0; we = 1'b0; ld_valid = 1'b0;
                check("hold_ready_gap", {cpu_hold, ld_ready}, 2'b11);
            end
            @(negedge clk);
            if (i == 0) held = data_out;
            if (disturb && i == 10) begin
                ld_start = 1'b1; ld_base = 8'h40; ld_len = 8'd1;
                we = 1'b1; addr = 8'h40; data_in = 8'h77;
            end else begin
                ld_start = 1'b0; we = 1'b0;
            end
            ld_valid = 1'b1; ld_data = ld_bytes[i];
            check("hold_ready_load", {cpu_hold, ld_ready}, 2'b11);
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_start = 1'b0; we = 1'b0;
        check("hold_ready_done", {cpu_hold, ld_ready}, 2'b00);
        check("data_out_held", data_out, held);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr = '0; data_in = '0; we = 1'b0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
`ifdef MEM_IO_PORT_EN
        io_in = 8'h5A;
`endif
        repeat (2) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_hold_ready", {cpu_hold, ld_ready}, 2'b00);
`ifdef MEM_IO_PORT_EN
        check("rst_io_out", io_out, 8'h00);
`endif
        rst_n = 1'b1;

        // Basic write/read and write-first
        cpu_cycle(8'hE1, 1'b1, 8'h0F, 8'h0F);
        cpu_cycle(8'hE1, 1'b0, 8'h00, 8'h0F);
        cpu_cycle(8'h10, 1'b1, 8'hA5, 8'hA5);
        cpu_cycle(8'h10, 1'b0, 8'h00, 8'hA5);
        idle_cycle();

        // Load with gaps
        ld_bytes[0] = 8'h05; ld_bytes[1] = 8'h00; ld_bytes[2] = 8'h00; ld_bytes[3] = 8'h00;
        do_load(8'h00, 4, 1'b1, 1'b0);
        cpu_cycle(8'h00, 1'b0, 8'h00, 8'h05);
        cpu_cycle(8'h01, 1'b0, 8'h00, 8'h00);
        cpu_cycle(8'h03, 1'b0, 8'h00, 8'h00);
        cpu_cycle(8'hE1, 1'b0, 8'h00, 8'h0F);

        // Loader byte outside LOAD is dropped
        cpu_cycle(8'h04, 1'b1, 8'h99, 8'h99);
        @(negedge clk);
        we = 1'b0; rd_issue = 1'b0; ld_valid = 1'b1; ld_data = 8'hEE;
        cpu_cycle(8'h04, 1'b0, 8'h00, 8'h99);
        idle_cycle();
        check("idle_no_hold", cpu_hold, 1'b0);

        // Address wrap
        ld_bytes[0] = 8'h11; ld_bytes[1] = 8'h22; ld_bytes[2] = 8'h33;
        do_load(8'hFE, 3, 1'b0, 1'b0);
        cpu_cycle(8'hFE, 1'b0, 8'h00, 8'h11);
`ifdef MEM_IO_PORT_EN
        cpu_cycle(8'hFF, 1'b0, 8'h00, 8'h5A);
`else
        cpu_cycle(8'hFF, 1'b0, 8'h00, 8'h22);
`endif
        cpu_cycle(8'h00, 1'b0, 8'h00, 8'h33);
        idle_cycle();

        // Full 256-byte load, disturbed by ld_start and a CPU write mid-load
        for (int i = 0; i < 256; i++) ld_bytes[i] = pat(i);
        do_load(8'h00, 256, 1'b0, 1'b1);
        cpu_cycle(8'h40, 1'b0, 8'h00, pat(8'h40));
        cpu_cycle(8'h00, 1'b0, 8'h00, pat(0));
        cpu_cycle(8'hFE, 1'b0, 8'h00, pat(8'hFE));
        cpu_cycle(8'h41, 1'b0, 8'h00, pat(8'h41));
        idle_cycle();

        // Reset during a load aborts it; accepted bytes remain
        @(negedge clk);
        ld_start = 1'b1; ld_base = 8'h80; ld_len = 8'd5;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'hAA;
        @(negedge clk);
        ld_data = 8'hBB;
        @(negedge clk);
        ld_valid = 1'b0; rst_n = 1'b0;
        check("pre_rst_hold", cpu_hold, 1'b1);
        @(negedge clk);
        check("abort_hold_ready", {cpu_hold, ld_ready}, 2'b00);
        check("abort_data_out", data_out, 8'h00);
        rst_n = 1'b1;
        cpu_cycle(8'h80, 1'b0, 8'h00, 8'hAA);
        cpu_cycle(8'h81, 1'b0, 8'h00, 8'hBB);
        idle_cycle();
        check("after_abort_idle", cpu_hold, 1'b0);

`ifdef MEM_IO_PORT_EN
        // Memory-mapped I/O register
        cpu_cycle(8'hFF, 1'b1, 8'h3C, 8'h3C);
        idle_cycle();
        check("io_out_write", io_out, 8'h3C);
        cpu_cycle(8'hFF, 1'b0, 8'h00, 8'h5A);
        idle_cycle();
`endif

        idle_cycle();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
